spi_master_fifo: RTL and testbench
==================================

// Module: spi_master_fifo
// PURPOSE
//   Memory-mapped SPI master, next generation of the single-byte SPI peripheral. Adds TX/RX FIFOs
//   for back-to-back bytes, all four SPI modes (CPOL/CPHA), LSB/MSB-first order and NUM_CS chip
//   selects. It sits on the core's simple valid/ready peripheral bus and drives external flash/SD/sensors.
// PARAMETERS
//   NUM_CS      4    number of active-low chip selects, 1..8
//   FIFO_DEPTH  8    entries per TX and RX FIFO, power of 2, >=2
//   DIV_RESET   100  reset value of CLKDIV
// PORTS
//   clk_i         in   1       clock; everything is on its rising edge
//   rst_i         in   1       reset, synchronous, active-high
//   req_valid_i   in   1       bus request
//   req_addr_i    in   32      byte address; only [5:0] is decoded
//   req_value_i   in   32      write data
//   req_wstrb_i   in   4       any bit set = write, all zero = read
//   req_ready_o   out  1       constant 1
//   resp_valid_o  out  1       1-cycle pulse, one cycle after every request
//   resp_value_o  out  32      read data; 0 for writes and unmapped addresses
//   spi_cs_n_o    out  NUM_CS  chip selects, active-low
//   spi_sck_o     out  1       serial clock
//   spi_mosi_o    out  1       serial data out
//   spi_miso_i    in   1       serial data in
// BEHAVIOUR
//   Reset: resp_valid_o=0, resp_value_o=0, spi_cs_n_o=all 1, spi_sck_o=0, spi_mosi_o=0.
//     FIFOs are emptied, CTRL=0, CLKDIV=DIV_RESET, sticky flags=0, FSM=IDLE.
//     A reset mid-byte aborts the byte immediately. No partial RX byte is pushed.
//   Register map (writes to RO and unmapped addresses are ignored):
//     0x00 TXDATA  W   push [7:0] to TX FIFO. If the FIFO is full the push is dropped and TX_OVF is set.
//     0x04 RXDATA  R   {23'b0, rx_empty, data}. Pops one entry if not empty. If empty it returns 0x100 and does not pop.
//     0x08 CS      RW  [NUM_CS-1:0] drives spi_cs_n_o directly (software-managed).
//     0x0C CLKDIV  RW  [15:0]; SCK half-period = CLKDIV+1 clk cycles.
//     0x10 STATUS  R   bit0 busy, 1 tx_full, 2 tx_empty, 3 rx_full, 4 rx_empty, 5 rx_ovf, 6 tx_ovf.
//                  W   write 1 to bit5 or bit6 to clear that flag. A set in the same cycle wins over a clear.
//     0x14 CTRL    RW  bit0 CPOL, bit1 CPHA, bit2 LSB_FIRST, bit3 RX_DISCARD (received bytes are not pushed).
//     0x18 LEVEL   R   [15:8] RX count, [7:0] TX count.
//   Read data is registered and appears with resp_valid_o on cycle t+1 for a request on cycle t.
//   FIFOs: count range 0..FIFO_DEPTH and pointers wrap mod FIFO_DEPTH.
//     A push while full is accepted only if a pop happens in the same cycle.
//     A push and pop together when empty are legal (the entry passes through at the next cycle).
//   FSM IDLE -> LOAD -> XFER -> IDLE:
//     IDLE: sck=CPOL. If TX not empty -> LOAD.
//     LOAD: one cycle. Pop TX, load the shifter, latch CPOL/CPHA/LSB_FIRST for this byte,
//       drive the first data bit on MOSI, busy=1.
//     XFER: tick counter 0..CLKDIV; on wrap sck toggles. 16 toggles per byte.
//       CPHA=0: sample MISO on odd (leading) edges, shift MOSI on even (trailing) edges, except after the 16th.
//       CPHA=1: shift MOSI on leading edges, sample MISO on trailing edges.
//       After the 16th toggle: push the RX byte unless RX_DISCARD.
//         If RX is full (and not popped that cycle) the byte is dropped and RX_OVF is set.
//       Then go to LOAD if TX is non-empty, else go to IDLE with busy=0.
//     Byte period = 16*(CLKDIV+1) cycles. Gap between back-to-back bytes = 1 cycle (LOAD).
//   CTRL or CLKDIV writes while busy take effect at the next LOAD (CLKDIV is compared live; software
//     must not change it mid-byte). A CPOL change while IDLE moves sck on the next cycle.
//   busy = (state != IDLE).
// TESTING
//   1 Reset -> read all registers: CS=all 1s, CLKDIV=100, STATUS=0x14, LEVEL=0; sck=0.
//   2 Loopback (MISO=MOSI), CLKDIV=1, mode 0: write 0xA5, 0x3C -> 2 bytes MSB first,
//     RX pops 0xA5 then 0x3C, then 0x100.
//   3 Modes 1/2/3 with LSB_FIRST and a slave model sending 0x81 -> sck idle level = CPOL,
//     sampling edge matches CPHA, rx = 0x81.
//   4 Push FIFO_DEPTH+2 bytes while CLKDIV=50 -> TX_OVF=1, exactly DEPTH+1 bytes sent (one in flight);
//     write 0x40 to STATUS clears the flag.
//   5 Never pop RX, send DEPTH+1 bytes -> rx_full=1, RX_OVF=1, the first DEPTH bytes are preserved in order.
//   6 Assert rst_i at byte mid-point -> next cycle sck=0, cs=all 1, busy=0, both FIFOs empty, nothing pushed to RX.

Source files
------------

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: memory-mapped SPI master with TX/RX FIFOs, four SPI modes and selectable bit order
module spi_master_fifo #(
  parameter int NUM_CS     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 100
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_value_i,
  input  logic [3:0]        req_wstrb_i,
  output logic              req_ready_o,
  output logic              resp_valid_o,
  output logic [31:0]       resp_value_o,
  output logic [NUM_CS-1:0] spi_cs_n_o,
  output logic              spi_sck_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;
  state_t            state_q;
  logic [7:0]        tx_mem [FIFO_DEPTH];
  logic [7:0]        rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [AW:0]       tx_cnt_q, rx_cnt_q;
  logic [NUM_CS-1:0] cs_q;
  logic [15:0]       div_q, tick_q;
  logic [3:0]        ctrl_q, edge_q;
  logic [7:0]        sh_q, rx_q, sh_d, rx_d;
  logic              cpha_q, lsb_q, sck_q, mosi_q, rx_ovf_q, tx_ovf_q, resp_valid_q;
  logic [31:0]       resp_value_q, rdata;
  logic [5:0]        addr;
  logic              wr, rd, tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push_req, tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
  logic              tog, lead, samp, shf, done, unused_bits;
  assign addr        = req_addr_i[5:0];
  assign wr          = req_valid_i && |req_wstrb_i;
  assign rd          = req_valid_i && !(|req_wstrb_i);
  assign tx_full     = tx_cnt_q == FULL;
  assign tx_empty    = tx_cnt_q == '0;
  assign rx_full     = rx_cnt_q == FULL;
  assign rx_empty    = rx_cnt_q == '0;
  assign tx_pop      = state_q == LOAD;
  assign tx_push_req = wr && addr == 6'h00;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop      = rd && addr == 6'h04 && !rx_empty;
  assign tog         = state_q == XFER && tick_q == div_q;
  assign lead        = !edge_q[0];
  assign samp        = tog && (lead != cpha_q);
  assign shf         = tog && (cpha_q ? lead && edge_q != 4'd0 : !lead && edge_q != 4'd15);
  assign done        = tog && edge_q == 4'd15;
  assign rx_push_req = done && !ctrl_q[3];
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign sh_d        = lsb_q ? {1'b0, sh_q[7:1]} : {sh_q[6:0], 1'b0};
  assign rx_d        = samp ? (lsb_q ? {spi_miso_i, rx_q[7:1]} : {rx_q[6:0], spi_miso_i}) : rx_q;
  assign unused_bits = ^{req_addr_i[31:6], req_value_i[31:16]};
  assign req_ready_o  = 1'b1;
  assign resp_valid_o = resp_valid_q;
  assign resp_value_o = resp_value_q;
  assign spi_cs_n_o   = cs_q;
  assign spi_sck_o    = sck_q;
  assign spi_mosi_o   = mosi_q;
  // read mux; an empty RX FIFO reads as 0x100 with the data field masked
  always_comb
    rdata = addr == 6'h04 ? {23'b0, rx_empty, rx_empty ? 8'h00 : rx_mem[rx_rp_q]} :
            addr == 6'h08 ? 32'(cs_q) :
            addr == 6'h0C ? {16'b0, div_q} :
            addr == 6'h10 ? {25'b0, tx_ovf_q, rx_ovf_q, rx_empty, rx_full, tx_empty, tx_full, state_q != IDLE} :
            addr == 6'h14 ? {28'b0, ctrl_q} :
            addr == 6'h18 ? {16'b0, 8'(rx_cnt_q), 8'(tx_cnt_q)} : 32'h0;
  // TX and RX FIFO pointers, counts and storage
  always_ff @(posedge clk_i)
    if (rst_i) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp_q] <= req_value_i[7:0];
        tx_wp_q         <= tx_wp_q + AW'(1);
      end
      if (tx_pop) tx_rp_q <= tx_rp_q + AW'(1);
      tx_cnt_q <= tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      if (rx_push) begin
        rx_mem[rx_wp_q] <= rx_d;
        rx_wp_q         <= rx_wp_q + AW'(1);
      end
      if (rx_pop) rx_rp_q <= rx_rp_q + AW'(1);
      rx_cnt_q <= rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  // bus response, software registers and sticky overflow flags (set beats clear)
  always_ff @(posedge clk_i)
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_value_q <= '0;
      cs_q         <= '1;
      div_q        <= 16'(DIV_RESET);
      ctrl_q       <= '0;
      tx_ovf_q     <= 1'b0;
      rx_ovf_q     <= 1'b0;
    end else begin
      resp_valid_q <= req_valid_i;
      resp_value_q <= rd ? rdata : 32'h0;
      if (wr && addr == 6'h08) cs_q <= req_value_i[NUM_CS-1:0];
      if (wr && addr == 6'h0C) div_q <= req_value_i[15:0];
      if (wr && addr == 6'h14) ctrl_q <= req_value_i[3:0];
      tx_ovf_q <= (tx_push_req && !tx_push) || (tx_ovf_q && !(wr && addr == 6'h10 && req_value_i[6]));
      rx_ovf_q <= (rx_push_req && !rx_push) || (rx_ovf_q && !(wr && addr == 6'h10 && req_value_i[5]));
    end
  // byte engine: LOAD latches the mode and first bit, XFER runs 16 SCK toggles
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      sh_q    <= '0;
      rx_q    <= '0;
      tick_q  <= '0;
      edge_q  <= '0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else
      case (state_q)
        IDLE: begin
          sck_q <= ctrl_q[0];
          if (!tx_empty) state_q <= LOAD;
        end
        LOAD: begin
          sh_q            <= tx_mem[tx_rp_q];
          mosi_q          <= ctrl_q[2] ? tx_mem[tx_rp_q][0] : tx_mem[tx_rp_q][7];
          {lsb_q, cpha_q} <= ctrl_q[2:1];
          sck_q           <= ctrl_q[0];
          rx_q            <= '0;
          tick_q          <= '0;
          edge_q          <= '0;
          state_q         <= XFER;
        end
        default: begin
          rx_q   <= rx_d;
          tick_q <= tog ? 16'd0 : tick_q + 16'd1;
          if (shf) begin
            sh_q   <= sh_d;
            mosi_q <= lsb_q ? sh_d[0] : sh_d[7];
          end
          if (tog) begin
            sck_q  <= !sck_q;
            edge_q <= edge_q + 4'd1;
          end
          if (done) state_q <= tx_empty ? IDLE : LOAD;
        end
      endcase
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: scoreboard bench for the FIFO SPI master
module tb_spi_master_fifo;
  localparam int NCS = 4, DEPTH = 8;
  logic           clk = 1'b0, rst;
  logic           req_valid, req_ready, resp_valid;
  logic [31:0]    req_addr, req_value, resp_value;
  logic [3:0]     req_wstrb;
  logic [NCS-1:0] cs_n;
  logic           sck, mosi, miso;
  logic           loop_en = 1'b1, slave_bit = 1'b0;
  logic           m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;
  logic [7:0]     sdata = 8'h00, cap = 8'h00;
  int             cnt = 0, idx;
  int             n_checks = 0, n_fail = 0;
  logic [31:0]    exp_q [$];
  always #5 clk = ~clk;
  assign miso = loop_en ? mosi : slave_bit;
  spi_master_fifo #(.NUM_CS(NCS), .FIFO_DEPTH(DEPTH), .DIV_RESET(100)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_value_i(req_value), .req_wstrb_i(req_wstrb), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_value_o(resp_value), .spi_cs_n_o(cs_n),
    .spi_sck_o(sck), .spi_mosi_o(mosi), .spi_miso_i(miso));
  // slave model: changes MISO on its launch edge, captures MOSI on the other edge
  always @(sck) begin
    if ((sck != m_cpol) == m_cpha) begin
      cnt++;
      idx = m_cpha ? cnt - 1 : cnt;
      if (idx < 8) slave_bit = sdata[m_lsb ? idx : 7 - idx];
    end else
      cap = m_lsb ? {mosi, cap[7:1]} : {cap[6:0], mosi};
  end
  task automatic bus(input logic [5:0] a, input logic [31:0] v, input logic w, output logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = {26'b0, a};
    req_value = v;
    req_wstrb = w ? 4'hF : 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    req_wstrb = 4'h0;
    d = resp_value;
  endtask
  task automatic bus_wr(input logic [5:0] a, input logic [31:0] v);
    logic [31:0] d;
    bus(a, v, 1'b1, d);
  endtask
  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
    bus(a, 32'h0, 1'b0, d);
  endtask
  task automatic wait_idle(input int budget);
    logic [31:0] s;
    int i;
    for (i = 0; i < budget; i++) begin
      bus_rd(6'h10, s);
      if ((s & 32'h5) == 32'h4) break;
    end
    n_checks++;
    if (i == budget) begin
      n_fail++;
      $display("FAIL wait_idle: status=%h still busy after %0d polls, want idle", s, budget);
    end
  endtask
  task automatic rx_check(input string name);
    logic [31:0] d, e;
    bus_rd(6'h04, d);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 32'h100;
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL %s: rxdata got %h want %h", name, d, e);
    end
  endtask
  task automatic test_reset;
    logic [5:0]  ra [8];
    logic [31:0] re [8];
    logic [31:0] d;
    ra = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C};
    re = '{32'h0, 32'h100, 32'hF, 32'd100, 32'h14, 32'h0, 32'h0, 32'h0};
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sck, mosi, cs_n, resp_valid, resp_value} !== {1'b0, 1'b0, 4'hF, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_pins: sck=%b mosi=%b cs=%h rv=%b rval=%h want 0 0 f 0 0", sck, mosi, cs_n, resp_valid, resp_value);
    end
    rst = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready: got %b want 1", req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      bus_rd(ra[i], d);
      n_checks++;
      if (d !== re[i]) begin
        n_fail++;
        $display("FAIL reset_reg_%h: got %h want %h", ra[i], d, re[i]);
      end
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if ({resp_valid, resp_value} !== {1'b1, 32'h14}) begin
      n_fail++;
      $display("FAIL resp_pulse: valid=%b value=%h want 1 00000014", resp_valid, resp_value);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_single: valid=%b want 0", resp_valid);
    end
    bus_wr(6'h18, 32'hFFFF);
    bus_rd(6'h18, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL ro_write: level got %h want 0", d);
    end
  endtask
  task automatic test_loopback;
    loop_en = 1'b1;
    {m_cpol, m_cpha, m_lsb} = 3'b000;
    bus_wr(6'h0C, 32'd1);
    bus_wr(6'h14, 32'h0);
    bus_wr(6'h08, 32'hE);
    n_checks++;
    if (cs_n !== 4'hE) begin
      n_fail++;
      $display("FAIL cs_drive: got %h want e", cs_n);
    end
    exp_q.push_back(32'hA5);
    bus_wr(6'h00, 32'hA5);
    exp_q.push_back(32'h3C);
    bus_wr(6'h00, 32'h3C);
    wait_idle(200);
    n_checks++;
    if (cap !== 8'h3C) begin
      n_fail++;
      $display("FAIL loop_mosi_order: captured %h want 3c", cap);
    end
    repeat (3) rx_check("loopback");
    n_checks++;
    if (sck !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_idle_sck: got %b want 0", sck);
    end
  endtask
  task automatic test_modes;
    logic [1:0] md;
    for (int m = 1; m < 4; m++) begin
      md = 2'(m);
      bus_wr(6'h0C, 32'd2);
      bus_wr(6'h14, {28'b0, 1'b0, 1'b1, md[0], md[1]});
      repeat (3) @(negedge clk);
      n_checks++;
      if (sck !== md[1]) begin
        n_fail++;
        $display("FAIL mode%0d_idle_sck: got %b want %b", m, sck, md[1]);
      end
      m_cpol = md[1];
      m_cpha = md[0];
      m_lsb = 1'b1;
      sdata = 8'h81;
      cnt = 0;
      loop_en = 1'b0;
      slave_bit = md[0] ? 1'b0 : sdata[0];
      exp_q.push_back(32'h81);
      bus_wr(6'h00, 32'h0B + 32'(m));
      wait_idle(200);
      rx_check("mode_rx");
      n_checks++;
      if (cap !== 8'(8'h0B + m)) begin
        n_fail++;
        $display("FAIL mode%0d_mosi: captured %h want %h", m, cap, 8'(8'h0B + m));
      end
      n_checks++;
      if (sck !== md[1]) begin
        n_fail++;
        $display("FAIL mode%0d_end_sck: got %b want %b", m, sck, md[1]);
      end
    end
    loop_en = 1'b1;
    bus_wr(6'h14, 32'h0);
  endtask
  task automatic test_tx_overflow;
    logic [31:0] d;
    {m_cpol, m_cpha, m_lsb} = 3'b000;
    bus_wr(6'h0C, 32'd50);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH + 1) exp_q.push_back(32'h10 + 32'(i));
      bus_wr(6'h00, 32'h10 + 32'(i));
    end
    bus_rd(6'h10, d);
    n_checks++;
    if (d[6] !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_ovf_set: status %h want bit6 set", d);
    end
    bus_wr(6'h10, 32'h40);
    bus_rd(6'h10, d);
    n_checks++;
    if (d[6] !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_ovf_clear: status %h want bit6 clear", d);
    end
    for (int i = 0; i < 12000 && exp_q.size() != 0; i++) begin
      logic [31:0] e;
      bus_rd(6'h04, d);
      if (d !== 32'h100) begin
        e = exp_q.pop_front();
        n_checks++;
        if (d !== e) begin
          n_fail++;
          $display("FAIL tx_ovf_data: rxdata got %h want %h", d, e);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL tx_ovf_timeout: %0d bytes missing, want 0", exp_q.size());
      exp_q.delete();
    end
    wait_idle(2000);
    rx_check("tx_ovf_extra");
    bus_rd(6'h10, d);
    n_checks++;
    if (d !== 32'h14) begin
      n_fail++;
      $display("FAIL tx_ovf_final_status: got %h want 14", d);
    end
  endtask
  task automatic test_rx_overflow;
    logic [31:0] d;
    bus_wr(6'h0C, 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) exp_q.push_back(32'h50 + 32'(i));
      bus_wr(6'h00, 32'h50 + 32'(i));
    end
    wait_idle(400);
    bus_rd(6'h10, d);
    n_checks++;
    if (d !== 32'h2C) begin
      n_fail++;
      $display("FAIL rx_ovf_status: got %h want 2c", d);
    end
    bus_rd(6'h18, d);
    n_checks++;
    if (d !== 32'h0800) begin
      n_fail++;
      $display("FAIL rx_ovf_level: got %h want 800", d);
    end
    repeat (DEPTH + 1) rx_check("rx_ovf_data");
    bus_wr(6'h10, 32'h20);
    bus_rd(6'h10, d);
    n_checks++;
    if (d !== 32'h14) begin
      n_fail++;
      $display("FAIL rx_ovf_clear: status %h want 14", d);
    end
  endtask
  task automatic test_reset_midbyte;
    logic [31:0] d;
    bus_wr(6'h14, 32'h1);
    bus_wr(6'h0C, 32'd50);
    bus_wr(6'h08, 32'h0);
    bus_wr(6'h00, 32'h77);
    bus_wr(6'h00, 32'h78);
    repeat (400) @(negedge clk);
    bus_rd(6'h10, d);
    n_checks++;
    if (d[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: status %h want busy", d);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({sck, mosi, cs_n} !== {1'b0, 1'b0, 4'hF}) begin
      n_fail++;
      $display("FAIL mid_reset_pins: sck=%b mosi=%b cs=%h want 0 0 f", sck, mosi, cs_n);
    end
    rst = 1'b0;
    bus_rd(6'h10, d);
    n_checks++;
    if (d !== 32'h14) begin
      n_fail++;
      $display("FAIL mid_reset_status: got %h want 14", d);
    end
    bus_rd(6'h18, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_level: got %h want 0", d);
    end
    repeat (20) @(negedge clk);
    rx_check("mid_reset_rx");
    bus_rd(6'h14, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_ctrl: got %h want 0", d);
    end
  endtask
  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'h0;
    req_value = 32'h0;
    req_wstrb = 4'h0;
    test_reset;
    test_loopback;
    test_modes;
    test_tx_overflow;
    test_rx_overflow;
    test_reset_midbyte;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
